// File: rtl/lsu_axi_master.sv
// lsu_axi_master
//   Bridges one LSU load/store request at a time onto an AXI4-Lite master port.
//   Loads are fetched as an aligned 8-byte beat and then byte-lane shifted and
//   sign/zero extended. Stores are shifted into their byte lanes and given a
//   matching strobe. Misaligned or illegal requests get an error response
//   straight away, and no bus traffic is issued for them.
//
// Ports
//   clk, rst (async, active-low)
//   req_*   : LSU request channel (valid/ready, load flag, funct3, addr, wdata)
//   resp_*  : completion channel (valid/ready, rdata, err)
//   m_ar*/m_r*          : AXI4-Lite read address / read data
//   m_aw*/m_w*/m_b*     : AXI4-Lite write address / write data / write response
//
// state   | meaning
// IDLE    | waiting for a request, req_ready = 1
// RD_ADDR | AR valid, waiting for m_arready
// RD_DATA | m_rready = 1, waiting for m_rvalid
// WR      | AW and W outstanding, each retired by its own handshake
// WR_RESP | m_bready = 1, waiting for m_bvalid
// RESP    | resp_valid = 1, waiting for resp_ready
module lsu_axi_master #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_load,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] m_araddr,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [XLEN-1:0] m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rvalid,
  output logic            m_rready,
  output logic [XLEN-1:0] m_awaddr,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [XLEN-1:0] m_wdata,
  output logic [7:0]      m_wstrb,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  logic [1:0]      m_bresp,
  input  logic            m_bvalid,
  output logic            m_bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP} state_e;

  state_e          state_q;
  logic [2:0]      funct3_q;
  logic [2:0]      off_q;
  logic            req_ready_q, resp_valid_q, resp_err_q;
  logic [XLEN-1:0] resp_rdata_q;
  logic [XLEN-1:0] araddr_q, awaddr_q, wdata_q;
  logic            arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic [7:0]      wstrb_q;

  function automatic logic req_bad(input logic ld, input logic [2:0] f3, input logic [2:0] a);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = a[0];
      2'b10:   mis = |a[1:0];
      default: mis = |a;
    endcase
    return mis | (ld ? (f3 == 3'b111) : f3[2]);
  endfunction

  function automatic logic [7:0] store_strb(input logic [1:0] sz, input logic [2:0] a);
    logic [7:0] base;
    case (sz)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << a;
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3)
      3'b000:  return {{(XLEN-8){d[7]}}, d[7:0]};
      3'b001:  return {{(XLEN-16){d[15]}}, d[15:0]};
      3'b010:  return {{(XLEN-32){d[31]}}, d[31:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, d[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, d[15:0]};
      3'b110:  return {{(XLEN-32){1'b0}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  logic [XLEN-1:0] rdata_d;
  assign rdata_d = load_ext(funct3_q, m_rdata >> {off_q, 3'b000});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      funct3_q     <= '0;
      off_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      araddr_q     <= '0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            funct3_q    <= req_funct3;
            off_q       <= req_addr[2:0];
            if (req_bad(req_load, req_funct3, req_addr[2:0])) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (req_load) begin
              state_q   <= RD_ADDR;
              arvalid_q <= 1'b1;
              araddr_q  <= {req_addr[XLEN-1:3], 3'b000};
            end else begin
              state_q   <= WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              awaddr_q  <= {req_addr[XLEN-1:3], 3'b000};
              wdata_q   <= req_wdata << {req_addr[2:0], 3'b000};
              wstrb_q   <= store_strb(req_funct3[1:0], req_addr[2:0]);
            end
          end else begin
            // Comes up 0 out of reset and rises on the first edge after release.
            req_ready_q <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid) begin
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= (m_rresp != 2'b00);
            resp_rdata_q <= (m_rresp != 2'b00) ? '0 : rdata_d;
            state_q      <= RESP;
          end
        end
        WR: begin
          if (m_awready) awvalid_q <= 1'b0;
          if (m_wready)  wvalid_q  <= 1'b0;
          // A channel is done if it already handshook or handshakes this cycle.
          if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= (m_bresp != 2'b00);
            resp_rdata_q <= '0;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign m_araddr   = araddr_q;
  assign m_arvalid  = arvalid_q;
  assign m_rready   = rready_q;
  assign m_awaddr   = awaddr_q;
  assign m_awvalid  = awvalid_q;
  assign m_wdata    = wdata_q;
  assign m_wstrb    = wstrb_q;
  assign m_wvalid   = wvalid_q;
  assign m_bready   = bready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_load;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_rresp, m_bresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [7:0]  m_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_axi_master #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle, then scramble the request inputs so the
  // DUT must rely on what it latched.
  task automatic issue(input logic ld, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd);
    req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0; req_load = ~ld; req_funct3 = 3'b111;
    req_addr = 64'hFFFF_FFFF_FFFF_FFFF; req_wdata = 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  task automatic finish_resp(input string tag, input logic [63:0] exp_rdata,
                             input logic exp_err, input int hold);
    chk({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd1);
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"}, {63'd0, resp_err}, {63'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, {63'd0, resp_valid}, 64'd1);
      chk({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
      chk({tag, "_hold_req_ready"}, {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, "_resp_drop"}, {63'd0, resp_valid}, 64'd0);
    chk({tag, "_req_ready_back"}, {63'd0, req_ready}, 64'd1);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] rd, input logic [1:0] rresp,
                         input logic [63:0] exp_rdata, input logic exp_err, input int hold);
    issue(1'b1, f3, a, 64'd0);
    chk({tag, "_arvalid"}, {63'd0, m_arvalid}, 64'd1);
    chk({tag, "_araddr"}, m_araddr, {a[63:3], 3'b000});
    chk({tag, "_req_ready_busy"}, {63'd0, req_ready}, 64'd0);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    chk({tag, "_arvalid_drop"}, {63'd0, m_arvalid}, 64'd0);
    chk({tag, "_rready"}, {63'd0, m_rready}, 64'd1);
    m_rvalid = 1'b1; m_rdata = rd; m_rresp = rresp;
    step();
    m_rvalid = 1'b0; m_rdata = 64'd0; m_rresp = 2'b00;
    chk({tag, "_rready_drop"}, {63'd0, m_rready}, 64'd0);
    finish_resp(tag, exp_rdata, exp_err, hold);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] exp_awaddr,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_strb,
                          input logic [1:0] bresp, input logic exp_err);
    issue(1'b0, f3, a, wd);
    chk({tag, "_awvalid"}, {63'd0, m_awvalid}, 64'd1);
    chk({tag, "_wvalid"}, {63'd0, m_wvalid}, 64'd1);
    chk({tag, "_awaddr"}, m_awaddr, exp_awaddr);
    chk({tag, "_wdata"}, m_wdata, exp_wdata);
    chk({tag, "_wstrb"}, {56'd0, m_wstrb}, {56'd0, exp_strb});
    m_awready = 1'b1; m_wready = 1'b1;
    step();
    m_awready = 1'b0; m_wready = 1'b0;
    chk({tag, "_aw_w_drop"}, {62'd0, m_awvalid, m_wvalid}, 64'd0);
    chk({tag, "_bready"}, {63'd0, m_bready}, 64'd1);
    m_bvalid = 1'b1; m_bresp = bresp;
    step();
    m_bvalid = 1'b0; m_bresp = 2'b00;
    chk({tag, "_bready_drop"}, {63'd0, m_bready}, 64'd0);
    finish_resp(tag, 64'd0, exp_err, 0);
  endtask

  task automatic do_bad(input string tag, input logic ld, input logic [2:0] f3,
                        input logic [63:0] a);
    issue(ld, f3, a, 64'hFFFF_FFFF);
    chk({tag, "_no_axi"}, {60'd0, m_arvalid, m_awvalid, m_wvalid, m_rready}, 64'd0);
    finish_resp(tag, 64'd0, 1'b1, 0);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_load = 1'b0; req_funct3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
    resp_ready = 1'b0;
    m_arready = 1'b0; m_rdata = 64'd0; m_rresp = 2'b00; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;

    repeat (2) step();
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_outputs", {57'd0, resp_valid, resp_err, m_arvalid, m_rready,
                        m_awvalid, m_wvalid, m_bready}, 64'd0);
    rst = 1'b1;
    step();
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

    do_load("lb",  3'b000, 64'h8000_0005, 64'h0000_8000_0000_0000, 2'b00,
            64'hFFFF_FFFF_FFFF_FF80, 1'b0, 0);
    do_load("lbu", 3'b100, 64'h8000_0005, 64'h0000_8000_0000_0000, 2'b00,
            64'h0000_0000_0000_0080, 1'b0, 4);
    do_load("lh",  3'b001, 64'h8000_0002, 64'h0000_0000_8001_0000, 2'b00,
            64'hFFFF_FFFF_FFFF_8001, 1'b0, 0);
    do_load("lhu", 3'b101, 64'h8000_0002, 64'h0000_0000_8001_0000, 2'b00,
            64'h0000_0000_0000_8001, 1'b0, 0);
    do_load("lw",  3'b010, 64'h8000_0004, 64'hDEAD_BEEF_0000_0000, 2'b00,
            64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 0);
    do_load("lwu", 3'b110, 64'h8000_0004, 64'hDEAD_BEEF_0000_0000, 2'b00,
            64'h0000_0000_DEAD_BEEF, 1'b0, 0);
    do_load("ld",  3'b011, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 2'b00,
            64'h0123_4567_89AB_CDEF, 1'b0, 0);
    do_load("ld_slverr", 3'b011, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 2'b10,
            64'd0, 1'b1, 0);

    do_store("sh", 3'b001, 64'h8000_0006, 64'h0000_0000_0000_1234, 64'h8000_0000,
             64'h1234_0000_0000_0000, 8'hC0, 2'b00, 1'b0);
    do_store("sb", 3'b000, 64'h8000_0003, 64'h0000_0000_0000_00AB, 64'h8000_0000,
             64'h0000_0000_AB00_0000, 8'h08, 2'b00, 1'b0);
    do_store("sd_err", 3'b011, 64'h8000_0018, 64'h1122_3344_5566_7788, 64'h8000_0018,
             64'h1122_3344_5566_7788, 8'hFF, 2'b11, 1'b1);

    do_bad("sw_mis", 1'b0, 3'b010, 64'h8000_0002);
    do_bad("lh_mis", 1'b1, 3'b001, 64'h8000_0001);
    do_bad("ld_mis", 1'b1, 3'b011, 64'h8000_0004);
    do_bad("ld_f3_111", 1'b1, 3'b111, 64'h8000_0000);
    do_bad("st_f3_100", 1'b0, 3'b100, 64'h8000_0000);

    // W accepted at once, AW held off for three cycles.
    issue(1'b0, 3'b010, 64'h8000_0014, 64'h0000_0000_CAFE_BABE);
    chk("split_wdata", m_wdata, 64'hCAFE_BABE_0000_0000);
    chk("split_wstrb", {56'd0, m_wstrb}, 64'h0000_0000_0000_00F0);
    m_wready = 1'b1;
    step();
    m_wready = 1'b0;
    chk("split_wvalid_drop", {63'd0, m_wvalid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("split_awvalid_held", {63'd0, m_awvalid}, 64'd1);
      chk("split_awaddr_held", m_awaddr, 64'h8000_0010);
      chk("split_no_bready", {63'd0, m_bready}, 64'd0);
      if (i == 2) m_awready = 1'b1;
      step();
    end
    m_awready = 1'b0;
    chk("split_awvalid_drop", {63'd0, m_awvalid}, 64'd0);
    chk("split_bready", {63'd0, m_bready}, 64'd1);
    m_bvalid = 1'b1;
    step();
    m_bvalid = 1'b0;
    finish_resp("split", 64'd0, 1'b0, 0);

    // Reset asserted mid-cycle while waiting for read data.
    issue(1'b1, 3'b011, 64'h8000_0020, 64'd0);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    chk("rd_data_rready", {63'd0, m_rready}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_rready", {63'd0, m_rready}, 64'd0);
    chk("async_rst_req_ready", {63'd0, req_ready}, 64'd0);
    #2 rst = 1'b1;
    step();
    chk("rst_release_req_ready", {63'd0, req_ready}, 64'd1);
    m_rvalid = 1'b1; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    m_rvalid = 1'b0; m_rdata = 64'd0;
    chk("stray_rvalid_ignored", {63'd0, resp_valid}, 64'd0);
    m_bvalid = 1'b1;
    step();
    m_bvalid = 1'b0;
    chk("stray_bvalid_ignored", {63'd0, resp_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
LSU_AXI_MASTER -- requirements
Module: lsu_axi_master

Interface
REQ-001 SHALL have parameter: XLEN, 64, data/address width (8-byte beats).
REQ-002 SHALL have port: clk  in  1  single clock, all state on posedge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-004 SHALL have port: req_valid  in  1  LSU request valid.
REQ-005 SHALL have port: req_ready  out  1  block accepts a request.
REQ-006 SHALL have port: req_load  in  1  1 = load, 0 = store.
REQ-007 SHALL have port: req_funct3  in  3  RISC-V load/store funct3.
REQ-008 SHALL have port: req_addr  in  XLEN  byte address.
REQ-009 SHALL have port: req_wdata  in  XLEN  store data, LSB-justified.
REQ-010 SHALL have port: resp_valid  out  1  completion valid.
REQ-011 SHALL have port: resp_ready  in  1  LSU consumes completion.
REQ-012 SHALL have port: resp_rdata  out  XLEN  extended load data (0 for stores or errors).
REQ-013 SHALL have port: resp_err  out  1  misaligned, illegal funct3 or bus error.
REQ-014 SHALL have ports: m_araddr out XLEN; m_arvalid out 1; m_arready in 1 (AXI4-Lite AR).
REQ-015 SHALL have ports: m_rdata in XLEN; m_rresp in 2; m_rvalid in 1; m_rready out 1 (AXI4-Lite R).
REQ-016 SHALL have ports: m_awaddr out XLEN; m_awvalid out 1; m_awready in 1 (AXI4-Lite AW).
REQ-017 SHALL have ports: m_wdata out XLEN; m_wstrb out 8; m_wvalid out 1; m_wready in 1 (AXI4-Lite W).
REQ-018 SHALL have ports: m_bresp in 2; m_bvalid in 1; m_bready out 1 (AXI4-Lite B).

Function
REQ-019 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL, on req_valid && req_ready, latch load, funct3, addr and wdata; the LSU may change inputs afterwards.
REQ-021 SHALL flag misalignment (halfword addr[0]!=0, word addr[1:0]!=0, dword addr[2:0]!=0) or illegal funct3 (load 3'b111, store funct3[2]=1), go directly to RESP with resp_err = 1, and issue no AXI transaction.
REQ-022 SHALL, for a legal load, go to RD_ADDR with m_arvalid = 1 and m_araddr = {addr[XLEN-1:3], 3'b000}; on m_arready go to RD_DATA with m_rready = 1.
REQ-023 SHALL, on m_rvalid in RD_DATA, shift m_rdata right by 8*addr[2:0], then sign- or zero-extend per funct3 (LB/LH/LW/LBU/LHU/LWU/LD), register the result into resp_rdata, and go to RESP.
REQ-024 SHALL, for a legal store, enter WR with m_awvalid = m_wvalid = 1, m_awaddr aligned as for reads, m_wdata = wdata << 8*addr[2:0], m_wstrb = {1,3,F,FF}[funct3[1:0]] << addr[2:0].
REQ-025 SHALL track AW and W handshakes independently: each valid drops after its own handshake, both may complete in the same cycle, and WR_RESP (m_bready = 1) is entered only after both complete.
REQ-026 SHALL go from WR_RESP to RESP on m_bvalid.
REQ-027 SHALL set resp_err = 1 and resp_rdata = 0 for a nonzero m_rresp or m_bresp.
REQ-028 SHALL hold each AXI valid, and its address/data/strobe, stable until the handshake; m_rvalid/m_bvalid outside RD_DATA/WR_RESP SHALL be ignored.
REQ-029 SHALL hold resp_valid = 1 in RESP with stable resp_rdata/resp_err until resp_ready, then return to IDLE on the next edge.
REQ-030 SHALL, when AXI ready/valid respond immediately, take: accept at cycle 0, arvalid at cycle 1, rvalid at cycle 2, resp_valid at cycle 3; a misaligned access SHALL give resp_valid at cycle 1.

Reset
REQ-031 SHALL, while rst = 0 and regardless of state, force state to IDLE and all outputs to 0, with req_ready = 0 during reset.
REQ-032 SHALL drive req_ready = 1 from the first cycle after rst deasserts; an in-flight AXI transaction is abandoned without a response.

Verification
REQ-033 SHALL pass: LB at 0x8000_0005, m_rdata 0x0000_8000_0000_0000 -> resp_rdata 0xFFFF_FFFF_FFFF_FF80; LBU at the same address -> 0x80.
REQ-034 SHALL pass: SH at 0x8000_0006, wdata 0x1234 -> m_awaddr 0x8000_0000, m_wstrb 8'hC0, m_wdata 0x1234_0000_0000_0000.
REQ-035 SHALL pass: SW at 0x8000_0002 -> no m_awvalid/m_wvalid, resp_err = 1, resp_valid one cycle after accept.
REQ-036 SHALL pass: m_wready = 1 immediately, m_awready delayed 3 cycles -> m_wvalid drops after 1 cycle, m_awvalid is held 4 cycles, and m_bready rises only after the AW handshake.
REQ-037 SHALL pass: load with m_rresp = 2'b10 -> resp_err = 1, resp_rdata = 0.
REQ-038 SHALL pass: resp_ready low for 4 cycles -> resp_valid and resp_rdata stable and req_ready = 0; rst pulsed low in RD_DATA -> outputs 0 immediately, req_ready = 1 after release.
